// File: rtl/scariv_credit_pool_if.sv
// Dispatch/return bus between the instruction buffer front end, the backend
// credit returners and the multi-channel credit pool.
interface scariv_credit_pool_if #(
  parameter int unsigned CH_NUM      = 4,
  parameter int unsigned MAX_CREDITS = 16,
  parameter int unsigned MAX_REQ     = 4,
  parameter int unsigned MAX_RET     = 4
);
  localparam int unsigned CW = $clog2(MAX_CREDITS + 1);
  localparam int unsigned RW = $clog2(MAX_REQ + 1);
  localparam int unsigned TW = $clog2(MAX_RET + 1);

  logic                 i_req_valid;
  logic [CH_NUM*RW-1:0] i_req_cnt;
  logic                 i_flush;
  logic                 o_grant_ok;
  logic [CH_NUM-1:0]    i_ret_valid;
  logic [CH_NUM*TW-1:0] i_ret_cnt;
  logic                 i_drain_req;
  logic                 o_drain_done;
  logic [CH_NUM*CW-1:0] o_credits;
  logic [CH_NUM-1:0]    o_low_water;
  logic [CH_NUM-1:0]    o_err_overflow;

  // Requester/returner side: drives dispatch groups, returns and drain.
  modport master (
    output i_req_valid, i_req_cnt, i_flush, i_ret_valid, i_ret_cnt, i_drain_req,
    input  o_grant_ok, o_drain_done, o_credits, o_low_water, o_err_overflow
  );

  // Credit pool side.
  modport slave (
    input  i_req_valid, i_req_cnt, i_flush, i_ret_valid, i_ret_cnt, i_drain_req,
    output o_grant_ok, o_drain_done, o_credits, o_low_water, o_err_overflow
  );
endinterface

// File: rtl/scariv_credit_pool.sv
// Multi-channel credit pool: atomic group grants, registered credit returns,
// drain state machine, low-water hints and sticky overflow flags.
module scariv_credit_pool #(
  parameter int unsigned CH_NUM      = 4,
  parameter int unsigned MAX_CREDITS = 16,
  parameter int unsigned MAX_REQ     = 4,
  parameter int unsigned MAX_RET     = 4,
  parameter int unsigned LOW_WATER   = 2
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  scariv_credit_pool_if.slave  bus
);
  localparam int unsigned CW = $clog2(MAX_CREDITS + 1);
  localparam int unsigned RW = $clog2(MAX_REQ + 1);
  localparam int unsigned TW = $clog2(MAX_RET + 1);
  localparam int unsigned SW = CW + 1;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic              drain_done_q, drain_done_d;
  logic [CW-1:0]     credits_q [CH_NUM];
  logic [CW-1:0]     credits_d [CH_NUM];
  logic [TW-1:0]     ret_q     [CH_NUM];
  logic [TW-1:0]     ret_d     [CH_NUM];
  logic [SW-1:0]     sum_c     [CH_NUM];
  logic [CH_NUM-1:0] ovf_q, ovf_d;
  logic [CH_NUM-1:0] low_q, low_d;
  logic              grant_c;
  logic              fire_c;
  logic              all_home_c;
  logic [CH_NUM*CW-1:0] credits_flat_c;

  // Group grant: every channel must cover its request from registered credits.
  always_comb begin
    grant_c = (state_q == ST_RUN);
    for (int c = 0; c < int'(CH_NUM); c++) begin
      if (SW'(bus.i_req_cnt[c*RW +: RW]) > SW'(credits_q[c])) begin
        grant_c = 1'b0;
      end
    end
  end

  assign fire_c = bus.i_req_valid & grant_c & ~bus.i_flush;

  // Net consumption and queued returns, clamping at the pool size.
  always_comb begin
    ovf_d = ovf_q;
    low_d = '0;
    for (int c = 0; c < int'(CH_NUM); c++) begin
      sum_c[c] = SW'(credits_q[c])
               - (fire_c ? SW'(bus.i_req_cnt[c*RW +: RW]) : SW'(0))
               + SW'(ret_q[c]);
      if (sum_c[c] > SW'(MAX_CREDITS)) begin
        credits_d[c] = CW'(MAX_CREDITS);
        ovf_d[c]     = 1'b1;
      end else begin
        credits_d[c] = CW'(sum_c[c]);
      end
      low_d[c] = (credits_d[c] <= CW'(LOW_WATER));
      ret_d[c] = bus.i_ret_valid[c] ? bus.i_ret_cnt[c*TW +: TW] : TW'(0);
    end
  end

  // Drain completes only when every credit is home and nothing is in flight.
  always_comb begin
    all_home_c = ~(|bus.i_ret_valid);
    for (int c = 0; c < int'(CH_NUM); c++) begin
      if ((credits_q[c] != CW'(MAX_CREDITS)) || (ret_q[c] != TW'(0))) begin
        all_home_c = 1'b0;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    drain_done_d = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (bus.i_drain_req) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (all_home_c) begin
          state_d      = ST_RUN;
          drain_done_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q      <= ST_RUN;
      drain_done_q <= 1'b0;
      ovf_q        <= '0;
      low_q        <= {CH_NUM{(MAX_CREDITS <= LOW_WATER)}};
      for (int c = 0; c < int'(CH_NUM); c++) begin
        credits_q[c] <= CW'(MAX_CREDITS);
        ret_q[c]     <= TW'(0);
      end
    end else begin
      state_q      <= state_d;
      drain_done_q <= drain_done_d;
      ovf_q        <= ovf_d;
      low_q        <= low_d;
      for (int c = 0; c < int'(CH_NUM); c++) begin
        credits_q[c] <= credits_d[c];
        ret_q[c]     <= ret_d[c];
      end
    end
  end

  always_comb begin
    credits_flat_c = '0;
    for (int c = 0; c < int'(CH_NUM); c++) begin
      credits_flat_c[c*CW +: CW] = credits_q[c];
    end
  end

  assign bus.o_grant_ok     = grant_c;
  assign bus.o_drain_done   = drain_done_q;
  assign bus.o_credits      = credits_flat_c;
  assign bus.o_low_water    = low_q;
  assign bus.o_err_overflow = ovf_q;

endmodule

// File: tb/tb_scariv_credit_pool.sv
// Self-checking bench for scariv_credit_pool: directed scenarios with literal
// expectations, then randomized traffic against a cycle-level pool model.
module tb_scariv_credit_pool;
  localparam int unsigned CH   = 4;
  localparam int unsigned MAXC = 16;
  localparam int unsigned MAXR = 4;
  localparam int unsigned MAXT = 4;
  localparam int unsigned LW   = 2;
  localparam int unsigned CW   = $clog2(MAXC + 1);
  localparam int unsigned RW   = $clog2(MAXR + 1);
  localparam int unsigned TW   = $clog2(MAXT + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  scariv_credit_pool_if #(.CH_NUM(CH), .MAX_CREDITS(MAXC), .MAX_REQ(MAXR), .MAX_RET(MAXT)) bus ();

  scariv_credit_pool #(
    .CH_NUM(CH), .MAX_CREDITS(MAXC), .MAX_REQ(MAXR), .MAX_RET(MAXT), .LOW_WATER(LW)
  ) dut (
    .i_clk(clk),
    .i_reset_n(rst_n),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural pool state: credits, returns in flight, drain mode, flags.
  int       m_cred [CH];
  int       m_ret  [CH];
  bit       m_drain = 1'b0;
  bit       m_done  = 1'b0;
  bit       m_init  = 1'b0;
  bit [CH-1:0] m_ovf = '0;

  function automatic int req_of(int c);
    return int'(bus.i_req_cnt[c*RW +: RW]);
  endfunction

  function automatic int cred(int c);
    return int'(bus.o_credits[c*CW +: CW]);
  endfunction

  function automatic bit model_grant();
    bit g = !m_drain;
    for (int c = 0; c < int'(CH); c++) if (req_of(c) > m_cred[c]) g = 1'b0;
    return g;
  endfunction

  always @(posedge clk) begin : model
    bit fire, home;
    int nx;
    if (!rst_n) begin
      m_init = 1'b1;
      for (int c = 0; c < int'(CH); c++) begin m_cred[c] = MAXC; m_ret[c] = 0; end
      m_drain = 1'b0; m_done = 1'b0; m_ovf = '0;
    end else if (m_init) begin
      fire = bus.i_req_valid && model_grant() && !bus.i_flush;
      home = 1'b1;
      for (int c = 0; c < int'(CH); c++)
        if (m_cred[c] != int'(MAXC) || m_ret[c] != 0 || bus.i_ret_valid[c]) home = 1'b0;
      for (int c = 0; c < int'(CH); c++) begin
        nx = m_cred[c] - (fire ? req_of(c) : 0) + m_ret[c];
        if (nx > int'(MAXC)) begin nx = MAXC; m_ovf[c] = 1'b1; end
        m_cred[c] = nx;
        m_ret[c]  = bus.i_ret_valid[c] ? int'(bus.i_ret_cnt[c*TW +: TW]) : 0;
      end
      m_done = 1'b0;
      if (!m_drain) begin
        if (bus.i_drain_req) m_drain = 1'b1;
      end else if (home) begin
        m_drain = 1'b0;
        m_done  = 1'b1;
      end
    end
  end

  // Per-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin : compare
    logic [CH*CW-1:0] e_cred;
    logic [CH-1:0]    e_low;
    if (m_init) begin
      for (int c = 0; c < int'(CH); c++) begin
        e_cred[c*CW +: CW] = CW'(m_cred[c]);
        e_low[c] = (m_cred[c] <= int'(LW));
      end
      n_tests += 5;
      if (bus.o_grant_ok !== model_grant()) begin
        n_fail++; $display("FAIL model_grant t=%0t got %0b expected %0b", $time, bus.o_grant_ok, model_grant());
      end
      if (bus.o_credits !== e_cred) begin
        n_fail++; $display("FAIL model_credits t=%0t got %h expected %h", $time, bus.o_credits, e_cred);
      end
      if (bus.o_low_water !== e_low) begin
        n_fail++; $display("FAIL model_low_water t=%0t got %b expected %b", $time, bus.o_low_water, e_low);
      end
      if (bus.o_err_overflow !== m_ovf) begin
        n_fail++; $display("FAIL model_overflow t=%0t got %b expected %b", $time, bus.o_err_overflow, m_ovf);
      end
      if (bus.o_drain_done !== m_done) begin
        n_fail++; $display("FAIL model_drain_done t=%0t got %0b expected %0b", $time, bus.o_drain_done, m_done);
      end
    end
  end

  always @(negedge clk) begin
    for (int c = 0; c < int'(CH); c++)
      assert (req_of(c) <= int'(MAXR)) else $error("illegal request count on channel %0d", c);
  end

  task automatic chk(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.i_req_valid = 1'b0;
    bus.i_req_cnt   = '0;
    bus.i_flush     = 1'b0;
    bus.i_ret_valid = '0;
    bus.i_ret_cnt   = '0;
    bus.i_drain_req = 1'b0;
  endtask

  task automatic set_req(int a0, int a1, int a2, int a3, bit v);
    bus.i_req_cnt[0*RW +: RW] = RW'(a0);
    bus.i_req_cnt[1*RW +: RW] = RW'(a1);
    bus.i_req_cnt[2*RW +: RW] = RW'(a2);
    bus.i_req_cnt[3*RW +: RW] = RW'(a3);
    bus.i_req_valid = v;
  endtask

  task automatic set_ret(int c, int n);
    bus.i_ret_valid[c] = 1'b1;
    bus.i_ret_cnt[c*TW +: TW] = TW'(n);
  endtask

  // Return credits until every channel is full with nothing in flight.
  task automatic fill_all();
    for (int k = 0; k < 40; k++) begin
      bit full;
      int room;
      full = 1'b1;
      idle();
      for (int c = 0; c < int'(CH); c++) begin
        room = int'(MAXC) - m_cred[c] - m_ret[c];
        if (m_cred[c] != int'(MAXC) || m_ret[c] != 0) full = 1'b0;
        if (room > 0) set_ret(c, (room > int'(MAXT)) ? int'(MAXT) : room);
      end
      if (full) break;
      step();
    end
    idle();
  endtask

  initial begin
    int first_done;
    int pulses;
    int r;
    int room;
    logic [CH*CW-1:0] all_full;
    all_full = {CH{CW'(MAXC)}};

    idle();
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    #1;
    chk("rst_credits", int'(bus.o_credits), int'(all_full));
    chk("rst_grant", int'(bus.o_grant_ok), 1);
    chk("rst_low_water", int'(bus.o_low_water), 0);
    chk("rst_overflow", int'(bus.o_err_overflow), 0);

    // Group consume then single-channel return.
    set_req(3, 0, 2, 1, 1'b1);
    step(); idle();
    chk("c1_ch0", cred(0), 13); chk("c1_ch1", cred(1), 16);
    chk("c1_ch2", cred(2), 14); chk("c1_ch3", cred(3), 15);
    set_ret(0, 3);
    step(); idle();
    chk("ret_ch0_pending", cred(0), 13);
    step();
    chk("ret_ch0_home", cred(0), 16);

    // Starve ch2 to a single credit.
    set_req(0, 0, 4, 0, 1'b1); step();
    set_req(0, 0, 4, 0, 1'b1); step();
    set_req(0, 0, 4, 0, 1'b1); step();
    set_req(0, 0, 1, 0, 1'b1); step();
    idle();
    set_req(0, 0, 2, 0, 1'b1);
    #1;
    chk("short_grant", int'(bus.o_grant_ok), 0);
    step();
    chk("short_ch2", cred(2), 1); chk("short_ch3", cred(3), 15);
    set_ret(2, 1);
    #1;
    chk("short_ret_grant0", int'(bus.o_grant_ok), 0);
    step(); idle(); set_req(0, 0, 2, 0, 1'b0);
    #1;
    chk("short_ret_grant1", int'(bus.o_grant_ok), 0);
    step();
    chk("short_ret_grant2", int'(bus.o_grant_ok), 1);
    chk("short_ret_ch2", cred(2), 2);

    // Flushed grant consumes nothing.
    idle(); set_req(1, 1, 1, 1, 1'b1); bus.i_flush = 1'b1;
    #1;
    chk("flush_grant", int'(bus.o_grant_ok), 1);
    step(); idle();
    chk("flush_ch0", cred(0), 16); chk("flush_ch2", cred(2), 2);

    // Simultaneous consume and return on ch1.
    set_req(0, 4, 0, 0, 1'b1); step();
    set_req(0, 2, 0, 0, 1'b1); step();
    chk("net_ch1_start", cred(1), 10);
    set_req(0, 2, 0, 0, 1'b1); set_ret(1, 3);
    step(); idle();
    chk("net_ch1_a", cred(1), 8);
    step();
    chk("net_ch1_b", cred(1), 11);

    // Overflow on ch3.
    set_ret(3, 1); step(); idle(); step();
    chk("ovf_ch3_full", cred(3), 16);
    set_ret(3, 1); step(); idle(); step();
    chk("ovf_ch3_clamp", cred(3), 16);
    chk("ovf_flag", int'(bus.o_err_overflow[3]), 1);
    step(); step();
    chk("ovf_sticky", int'(bus.o_err_overflow[3]), 1);

    // Drain with ch0 at 12 and four single-credit returns.
    fill_all();
    set_req(4, 0, 0, 0, 1'b1); step(); idle();
    chk("drain_ch0_start", cred(0), 12);
    bus.i_drain_req = 1'b1;
    step();
    first_done = -1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      idle();
      set_req(1, 1, 1, 1, 1'b0);
      if (i < 4) set_ret(0, 1);
      #1;
      if (bus.o_drain_done) begin
        pulses++;
        if (first_done < 0) first_done = i;
      end
      if (i < 6) chk("drain_grant_blocked", int'(bus.o_grant_ok), 0);
      if (i == 6) chk("drain_grant_resumed", int'(bus.o_grant_ok), 1);
      step();
    end
    chk("drain_done_cycle", first_done, 6);
    chk("drain_done_pulses", pulses, 1);

    // Reset in the middle of a drain with returns in flight.
    idle(); set_req(4, 0, 0, 0, 1'b1); step();
    idle(); bus.i_drain_req = 1'b1; step();
    idle(); set_ret(0, 2); step();
    idle(); set_ret(0, 2); rst_n = 1'b0; step();
    rst_n = 1'b1; idle();
    #1;
    chk("mid_rst_credits", int'(bus.o_credits), int'(all_full));
    chk("mid_rst_overflow", int'(bus.o_err_overflow), 0);
    chk("mid_rst_grant", int'(bus.o_grant_ok), 1);
    for (int i = 0; i < 4; i++) begin
      chk("mid_rst_no_pulse", int'(bus.o_drain_done), 0);
      step();
    end

    // Randomized traffic checked by the per-cycle compare.
    for (int n = 0; n < 3000; n++) begin
      idle();
      rst_n = ($urandom_range(0, 499) != 0);
      set_req(($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, MAXR)),
              ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, MAXR)),
              ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, MAXR)),
              ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, MAXR)),
              1'($urandom_range(0, 1)));
      bus.i_flush     = ($urandom_range(0, 9) == 0);
      bus.i_drain_req = ($urandom_range(0, 49) == 0);
      for (int c = 0; c < int'(CH); c++) begin
        if ($urandom_range(0, 2) == 0) begin
          r = int'($urandom_range(1, MAXT));
          room = int'(MAXC) - m_cred[c] - m_ret[c];
          if ($urandom_range(0, 49) != 0 && r > room) r = room;
          if (r > 0) set_ret(c, r);
        end
      end
      step();
    end
    rst_n = 1'b1;
    idle();
    step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
